// File: rtl/piso_arb_ctrl_pkg.sv
// rtl/piso_arb_ctrl_pkg.sv - shared state encoding and default parameters for piso_arb_ctrl
package piso_arb_ctrl_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_GAP   = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

endpackage

// File: rtl/piso_arb_ctrl_piso_reg.sv
// rtl/piso_arb_ctrl_piso_reg.sv - WIDTH-bit parallel-load, MSB-first shift register
module piso_reg
   import piso_arb_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ld,
   input  logic             shift_en,
   input  logic             sin,
   input  logic [WIDTH-1:0] pdata,
   output logic             msb
);

   logic [WIDTH-1:0] q;

   // Shift via << so the same expression holds for WIDTH == 1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= '0;
      end else if (ld) begin
         q <= pdata;
      end else if (shift_en) begin
         q <= (q << 1) | WIDTH'(sin);
      end
   end

   assign msb = q[WIDTH-1];

endmodule

// File: rtl/piso_arb_ctrl.sv
// rtl/piso_arb_ctrl.sv - two-requester round-robin arbiter feeding a framed serialiser
module piso_arb_ctrl
   import piso_arb_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int GAP   = DEF_GAP
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   output logic [1:0]       gnt,
   output logic             sout,
   output logic             sout_valid,
   output logic             sout_src,
   output logic             done,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int GW = (GAP < 2) ? 1 : $clog2(GAP + 1);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [GW-1:0]    gap_cnt;
   logic             prio;
   logic             win;
   logic             ld;
   logic             shift_en;
   logic             msb;
   logic [WIDTH-1:0] sel_word;

   // prio names the requester that wins a tie; it flips to the loser after every grant.
   always_comb begin
      win = 1'b0;
      if (req == 2'b11) begin
         win = prio;
      end else begin
         win = req[1];
      end
   end

   assign ld       = (state == ST_LOAD);
   assign shift_en = (state == ST_SHIFT);
   assign sel_word = sout_src ? data1 : data0;
   assign sout     = msb & sout_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         gap_cnt    <= '0;
         prio       <= 1'b0;
         gnt        <= 2'b00;
         sout_valid <= 1'b0;
         sout_src   <= 1'b0;
         done       <= 1'b0;
         busy       <= 1'b0;
      end else begin
         gnt  <= 2'b00;
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (|req) begin
                  state    <= ST_LOAD;
                  gnt      <= win ? 2'b10 : 2'b01;
                  sout_src <= win;
                  prio     <= ~win;
                  busy     <= 1'b1;
               end
            end
            ST_LOAD: begin
               state      <= ST_SHIFT;
               cnt        <= CW'(WIDTH);
               sout_valid <= 1'b1;
               done       <= (WIDTH == 1);
            end
            ST_SHIFT: begin
               // cnt holds the number of bits still to leave, including the one on sout now.
               if (cnt == CW'(1)) begin
                  cnt        <= '0;
                  sout_valid <= 1'b0;
                  if (GAP == 0) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state   <= ST_GAP;
                     gap_cnt <= GW'(GAP);
                  end
               end else begin
                  cnt  <= cnt - CW'(1);
                  done <= (cnt == CW'(2));
               end
            end
            ST_GAP: begin
               if (gap_cnt == GW'(1)) begin
                  state   <= ST_IDLE;
                  gap_cnt <= '0;
                  busy    <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt - GW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   piso_reg #(.WIDTH(WIDTH)) u_piso_reg (
      .clk      (clk),
      .reset    (reset),
      .ld       (ld),
      .shift_en (shift_en),
      .sin      (1'b0),
      .pdata    (sel_word),
      .msb      (msb)
   );

endmodule

// File: doc/piso_arb_ctrl.md
PISO_ARB_CTRL -- requirements
Module: piso_arb_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: shift-register width and bits per frame.
REQ-002 Parameter GAP, default 1: idle cycles inserted after each frame. 0 is legal.
REQ-003 Port clk, input, 1: clock. All state changes on the rising edge.
REQ-004 Port reset, input, 1: reset, asynchronous, active-low.
REQ-005 Port req, input, 2: level request per requester. Held until the matching gnt bit pulses.
REQ-006 Port data0, input, WIDTH: parallel word of requester 0. Stable while req[0] is high.
REQ-007 Port data1, input, WIDTH: parallel word of requester 1. Stable while req[1] is high.
REQ-008 Port gnt, output, 2: one-hot, one-cycle grant pulse. The word is loaded on that cycle's clock edge.
REQ-009 Port sout, output, 1: serial data, MSB first. Forced to 0 when sout_valid is low.
REQ-010 Port sout_valid, output, 1: high while a frame bit is on sout.
REQ-011 Port sout_src, output, 1: index of the requester owning the current frame.
REQ-012 Port done, output, 1: one-cycle pulse coincident with the last bit of a frame.
REQ-013 Port busy, output, 1: high in every state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, SHIFT and GAP.
REQ-015 IDLE with any req bit high SHALL go to LOAD; otherwise IDLE SHALL hold.
REQ-016 LOAD SHALL last exactly 1 cycle with these actions:
- arbitrate and assert the one-hot gnt bit;
- assert ld to the shift register;
- latch sout_src.
REQ-017 Arbitration SHALL be round-robin:
- a lone request wins;
- on simultaneous requests, the requester not granted last wins;
- after reset, requester 0 has priority.
REQ-018 SHIFT SHALL last exactly WIDTH cycles, with sout_valid=1 and sout = data[WIDTH-1], then data[WIDTH-2], down to data[0].
REQ-019 Each shifted-in serial bit SHALL be 0.
REQ-020 A down-counter of width clog2(WIDTH+1) SHALL track SHIFT.
- done SHALL pulse when the counter reaches its last bit.
- The next state SHALL be GAP, or IDLE if GAP==0.
REQ-021 GAP SHALL last exactly GAP cycles, then go to IDLE. Requests are ignored during GAP.
REQ-022 Frame cadence for a continuously held request SHALL be 1+WIDTH+GAP+1 cycles, grant to grant (includes the IDLE cycle).
REQ-023 A req deasserted before gnt SHALL be dropped with no grant. A req deasserted after gnt SHALL NOT abort the frame.
REQ-024 If req is still high after gnt (a new word), it SHALL be re-arbitrated on the next IDLE.
REQ-025 gnt SHALL never be asserted outside LOAD. At most one gnt bit SHALL be high.

Reset
REQ-026 Reset low SHALL immediately (asynchronously) force:
- state IDLE;
- counter 0, shift register 0;
- round-robin pointer to requester 0;
- gnt=0, sout=0, sout_valid=0, sout_src=0, done=0, busy=0.
REQ-027 Reset mid-frame SHALL discard the partial frame with no done pulse.
REQ-028 Arbitration after reset release SHALL start no earlier than the first rising edge with reset high.

Structure
REQ-029 A shared package SHALL hold:
- the state encoding constants IDLE/LOAD/SHIFT/GAP;
- the default values of WIDTH and GAP.
REQ-030 The datapath SHALL be one sub-module, piso_reg, a WIDTH-bit shift register with:
- ld-selected parallel load and serial-in;
- async active-low reset.
The controller drives ld, the selected word and serial-in=0.

Verification (WIDTH=4, GAP=1 unless noted)
REQ-031 Single request: req[0]=1, data0=4'b1011, gnt[0] at cycle N -> sout_valid in N+1..N+4 with sout 1,0,1,1; done at N+4; sout_src=0; busy low at N+6.
REQ-032 Simultaneous requests from reset: req=2'b11, data0=4'hA, data1=4'h5 -> gnt order 0,1,0,1; serial 1010 then 0101; grants 7 cycles apart.
REQ-033 Lone held requester: req[1] held, data1=4'hF -> gnt[1] every 7 cycles; gnt[0] never asserted.
REQ-034 Reset mid-frame: assert reset after 2 bits of 4'b1100 -> all outputs 0 the same cycle, no done; after release, the held req[0] is re-granted and the full 1,1,0,0 sent.
REQ-035 GAP=0: held req[0] -> grants every 6 cycles; IDLE still appears between frames.
REQ-036 Dropped request: req[1] pulsed for 1 cycle during SHIFT of a frame for requester 0 -> no gnt[1] is issued.
